// File: rtl/mult4x4_cmpx_ctrl.sv
// Controller for the 4x4 complex-multiplier datapath.
// Sequences four real products through the shared multiplier:
// re = xz - yw, im = xw + yz. It also runs a watchdog on the
// multiplier handshake.
module mult4x4_cmpx_ctrl #(
  parameter int unsigned WAIT_LIMIT = 64,
  parameter int unsigned CW         = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic done4x4,
  output logic ldx,
  output logic ldy,
  output logic ldz,
  output logic ldw,
  output logic initR,
  output logic initI,
  output logic sel1,
  output logic sel2,
  output logic start4x4,
  output logic sel3,
  output logic sub,
  output logic ldR,
  output logic ldI,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MSTART,
    MWAIT,
    ACC,
    FIN,
    ERR
  } state_t;

  localparam logic [CW-1:0] WD_LAST = CW'(WAIT_LIMIT - 1);

  state_t        state, state_nxt;
  logic [1:0]    k, k_nxt;
  logic [CW-1:0] wd, wd_nxt;
  logic          err_nxt;

  // State, product index, watchdog and sticky error registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      k     <= '0;
      wd    <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      wd    <= wd_nxt;
      err   <= err_nxt;
    end
  end

  // Next-state logic; wd==0 marks the MWAIT guard cycle where a stale done4x4 is ignored
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    wd_nxt    = wd;
    err_nxt   = err;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          err_nxt   = 1'b0;
        end
      end
      LOAD: begin
        k_nxt     = '0;
        state_nxt = MSTART;
      end
      MSTART: begin
        wd_nxt    = '0;
        state_nxt = MWAIT;
      end
      MWAIT: begin
        if ((wd != '0) && done4x4) begin
          state_nxt = ACC;
        end else if (wd == WD_LAST) begin
          state_nxt = ERR;
        end else begin
          wd_nxt = wd + CW'(1);
        end
      end
      ACC: begin
        if (k == 2'd3) begin
          state_nxt = FIN;
        end else begin
          k_nxt     = k + 2'd1;
          state_nxt = MSTART;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      ERR: begin
        err_nxt   = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state/k, so each one is valid in the cycle of the state it decodes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ldx      <= 1'b0;
      ldy      <= 1'b0;
      ldz      <= 1'b0;
      ldw      <= 1'b0;
      initR    <= 1'b0;
      initI    <= 1'b0;
      sel1     <= 1'b0;
      sel2     <= 1'b0;
      start4x4 <= 1'b0;
      sel3     <= 1'b0;
      sub      <= 1'b0;
      ldR      <= 1'b0;
      ldI      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      ldx      <= 1'b0;
      ldy      <= 1'b0;
      ldz      <= 1'b0;
      ldw      <= 1'b0;
      initR    <= 1'b0;
      initI    <= 1'b0;
      sel1     <= 1'b0;
      sel2     <= 1'b0;
      start4x4 <= 1'b0;
      sel3     <= 1'b0;
      sub      <= 1'b0;
      ldR      <= 1'b0;
      ldI      <= 1'b0;
      busy     <= (state_nxt != IDLE) && (state_nxt != ERR);
      done     <= 1'b0;
      unique case (state_nxt)
        LOAD: begin
          ldx   <= 1'b1;
          ldy   <= 1'b1;
          ldz   <= 1'b1;
          ldw   <= 1'b1;
          initR <= 1'b1;
          initI <= 1'b1;
        end
        MSTART, MWAIT, ACC: begin
          // k0: xz to re, k1: yw from re, k2: xw to im, k3: yz to im
          sel1     <= k_nxt[0];
          sel2     <= k_nxt[0] ^ k_nxt[1];
          sel3     <= ~k_nxt[1];
          sub      <= (k_nxt == 2'd1);
          start4x4 <= (state_nxt == MSTART);
          ldR      <= (state_nxt == ACC) && !k_nxt[1];
          ldI      <= (state_nxt == ACC) &&  k_nxt[1];
        end
        FIN: begin
          done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult4x4_cmpx_ctrl.sv
// Bench for mult4x4_cmpx_ctrl: a behavioural datapath and a real multiplier
// with selectable latency/behaviour sit around the controller. Results are
// compared against plain complex arithmetic and the latency formula 4L+10.
module tb_mult4x4_cmpx_ctrl;

  logic clk = 1'b0;
  logic rst, start, done4x4;
  logic ldx, ldy, ldz, ldw, initR, initI, sel1, sel2, start4x4;
  logic sel3, sub, ldR, ldI, busy, done, err;

  logic [7:0] a, b;
  int         mode;  // 0: done pulse after lat cycles, 1: done held high, 2: never done
  int         lat;
  int         n_checks = 0;
  int         n_err    = 0;

  // Expected {sel1,sel2,sel3,sub} for products k0..k3
  logic [3:0] ktab [4] = '{4'b0010, 4'b1111, 4'b0100, 4'b1000};

  mult4x4_cmpx_ctrl #(.WAIT_LIMIT(8), .CW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .done4x4(done4x4),
    .ldx(ldx), .ldy(ldy), .ldz(ldz), .ldw(ldw),
    .initR(initR), .initI(initI), .sel1(sel1), .sel2(sel2),
    .start4x4(start4x4), .sel3(sel3), .sub(sub), .ldR(ldR), .ldI(ldI),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Datapath model
  logic [3:0] px, py, pz, pw;
  logic [7:0] re_r, im_r, prod, opnd, sum;
  int         cnt;

  assign opnd = sel3 ? re_r : im_r;
  assign sum  = sub ? (opnd - prod) : (opnd + prod);

  always @(posedge clk) begin
    if (ldx) px <= a[7:4];
    if (ldy) py <= a[3:0];
    if (ldz) pz <= b[7:4];
    if (ldw) pw <= b[3:0];
    if (initR) re_r <= '0;
    if (initI) im_r <= '0;
    if (ldR) re_r <= sum;
    if (ldI) im_r <= sum;
  end

  // Real multiplier model
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      done4x4 <= 1'b0;
      cnt     <= 0;
    end else begin
      if (start4x4) prod <= {4'b0, (sel1 ? py : px)} * {4'b0, (sel2 ? pw : pz)};
      case (mode)
        0: begin
          if (start4x4) begin
            cnt     <= lat - 1;
            done4x4 <= 1'b0;
          end else if (cnt > 0) begin
            cnt     <= cnt - 1;
            done4x4 <= (cnt == 1);
          end else begin
            done4x4 <= 1'b0;
          end
        end
        1: begin
          done4x4 <= done4x4 | start4x4;
          cnt     <= 0;
        end
        default: begin
          done4x4 <= 1'b0;
          cnt     <= 0;
        end
      endcase
    end
  end

  function automatic logic [15:0] outs();
    return {ldx, ldy, ldz, ldw, initR, initI, sel1, sel2, start4x4,
            sel3, sub, ldR, ldI, busy, done, err};
  endfunction

  function automatic logic [15:0] ref_out(input logic [7:0] a_i, input logic [7:0] b_i);
    int x, y, z, w, re, im;
    x  = int'(a_i[7:4]);
    y  = int'(a_i[3:0]);
    z  = int'(b_i[7:4]);
    w  = int'(b_i[3:0]);
    re = x * z - y * w;
    im = x * w + y * z;
    return {re[7:0], im[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One complex multiply from an idle controller; call at a negedge
  task automatic run_op(input logic [7:0] a_i, input logic [7:0] b_i, input int md,
                        input int l, input string tag, input int exp_done);
    int t, first_done, n_acc, n_st;
    mode = md;
    lat  = l;
    repeat (2) @(negedge clk);
    a = a_i;
    b = b_i;
    start = 1'b1;
    t = 0;
    first_done = -1;
    n_acc = 0;
    n_st = 0;
    while (first_done < 0 && t < 300) begin
      @(negedge clk);
      t++;
      if (t == 1) begin
        start = 1'b0;
        chk({tag, "_err_clear_at_load"}, {err, ldx, initR, initI}, 4'b0111);
      end
      if (start4x4) begin
        if (n_st < 4) chk({tag, "_mstart_ctrl"}, {sel1, sel2, sel3, sub, ldR, ldI}, {ktab[n_st], 2'b00});
        else chk({tag, "_extra_start4x4"}, 1'b1, 1'b0);
        n_st++;
      end
      if (ldR || ldI) begin
        if (n_acc < 4) chk({tag, "_acc_ctrl"}, {sel1, sel2, sel3, sub, ldR, ldI},
                           {ktab[n_acc], 1'(n_acc < 2), 1'(n_acc >= 2)});
        n_acc++;
      end
      if (done) first_done = t;
    end
    chk({tag, "_done_cycle"}, first_done, exp_done);
    chk({tag, "_out"}, {re_r, im_r}, ref_out(a_i, b_i));
    chk({tag, "_acc_count"}, n_acc, 4);
  endtask

  initial begin
    logic [7:0] ra, rb;
    int         rl, n_done, d1, d2;

    rst = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    mode = 0;
    lat = 4;
    @(negedge clk);
    chk("reset_outs", outs(), 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    // Reference vectors
    run_op(8'h32, 8'h21, 0, 4, "t1", 26);
    run_op(8'h12, 8'h34, 0, 4, "t2", 26);

    // Random operands and latencies
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rl = int'($urandom_range(2, 6));
      run_op(ra, rb, 0, rl, "rand", 4 * rl + 10);
    end

    // done4x4 held high: each MWAIT is guard + accept
    run_op(8'hF7, 8'h9C, 1, 4, "t4_hold", 18);

    // start held through the run and three cycles beyond
    mode = 0;
    lat = 4;
    repeat (2) @(negedge clk);
    a = 8'hA5;
    b = 8'h3E;
    start = 1'b1;
    n_done = 0;
    d1 = -1;
    d2 = -1;
    for (int t = 1; t <= 70; t++) begin
      @(negedge clk);
      if (t == 30) start = 1'b0;
      if (done) begin
        n_done++;
        if (d1 < 0) d1 = t;
        else if (d2 < 0) d2 = t;
      end
      if (t == 27) chk("t3_idle_after_fin", busy, 1'b0);
      if (t == 28) chk("t3_second_load", ldx, 1'b1);
    end
    chk("t3_done_count", n_done, 2);
    chk("t3_first_done", d1, 26);
    chk("t3_second_done", d2, 53);
    chk("t3_out", {re_r, im_r}, ref_out(8'hA5, 8'h3E));

    // Watchdog abort
    mode = 2;
    repeat (2) @(negedge clk);
    a = 8'h44;
    b = 8'h55;
    start = 1'b1;
    n_done = 0;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      if (t == 1) start = 1'b0;
      if (done) n_done++;
      if (t == 10) chk("t5_last_mwait_busy", busy, 1'b1);
      if (t == 11) chk("t5_err_state_busy", busy, 1'b0);
      if (t == 12) chk("t5_err_set", {err, busy}, 2'b10);
    end
    chk("t5_no_done", n_done, 0);
    chk("t5_err_sticky", err, 1'b1);
    run_op(8'h63, 8'h72, 0, 3, "t5_recover", 22);

    // Asynchronous reset in the k=2 MWAIT
    mode = 0;
    lat = 4;
    repeat (2) @(negedge clk);
    a = 8'h9B;
    b = 8'hD4;
    start = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      @(negedge clk);
      if (t == 1) start = 1'b0;
    end
    chk("t6_in_k2_mwait", {sel1, sel2, sel3, sub, busy, start4x4}, 6'b010010);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_reset_outs", outs(), 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("t6_idle_after_reset", {busy, done, start4x4, ldx}, 4'b0000);
    end
    run_op(8'h9B, 8'hD4, 0, 4, "t6_fresh", 26);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
